// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite sequencer: scans the attribute RAM for sprites covering line_y and
// launches the sprite drawer once per hit. Define SPRITE_SCHED_PRIORITY_REV_EN to scan high-to-low.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 32,
  parameter int MAX_PER_LINE = 16,
  parameter int SPR_H        = 16,
  localparam int AW          = $clog2(NUM_SPRITES)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          line_start,
  input  logic [9:0]    line_y,
  output logic [AW-1:0] attr_addr,
  input  logic [31:0]   attr_q,
  output logic          drw_start,
  output logic [9:0]    drw_col_base,
  output logic          drw_flip,
  output logic [7:0]    drw_frame_id,
  output logic [3:0]    drw_row_off,
  input  logic          drw_done,
  output logic          busy,
  output logic          line_done,
  output logic          overflow,
  output logic          line_overrun
);

  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam logic [CW-1:0] HIT_MAX = CW'(MAX_PER_LINE);
  localparam logic [9:0]    ROWS    = 10'(SPR_H);

`ifdef SPRITE_SCHED_PRIORITY_REV_EN
  // Descending scan: the last launch (sprite 0) lands on top in the linebuffer.
  localparam logic [AW-1:0] IDX_FIRST = AW'(NUM_SPRITES - 1);
  localparam logic [AW-1:0] IDX_LAST  = '0;
  localparam logic [AW-1:0] IDX_STEP  = '1;
`else
  localparam logic [AW-1:0] IDX_FIRST = '0;
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_SPRITES - 1);
  localparam logic [AW-1:0] IDX_STEP  = AW'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   idx;
  logic [CW-1:0]   hit_cnt;
  logic [9:0]      line_y_p0;
  logic signed [10:0] delta_p1;
  logic            hit_p1;
  logic            cap_p1;
  logic            unused_attr;

  // Signed row distance; a negative result means the sprite starts below this line.
  function automatic logic signed [10:0] row_delta(input logic [9:0] ly, input logic [9:0] sy);
    return $signed({1'b0, ly}) - $signed({1'b0, sy});
  endfunction

  function automatic logic row_hit(input logic en, input logic signed [10:0] d);
    return en && !d[10] && (d[9:0] < ROWS);
  endfunction

  assign unused_attr = ^attr_q[11:10];
  assign attr_addr   = idx;
  assign drw_start   = (state == S_LAUNCH);

  // CHECK stage: attribute word returned for the address driven in FETCH
  assign delta_p1 = row_delta(line_y_p0, attr_q[21:12]);
  assign hit_p1   = row_hit(attr_q[31], delta_p1);
  assign cap_p1   = (hit_cnt == HIT_MAX);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (line_start) state_next = S_FETCH;
      S_FETCH:  state_next = S_CHECK;
      S_CHECK:  state_next = (hit_p1 && !cap_p1) ? S_LAUNCH : S_NEXT;
      S_LAUNCH: state_next = S_ARM;
      S_ARM:    state_next = S_WAIT;
      S_WAIT:   if (drw_done) state_next = S_NEXT;
      S_NEXT:   state_next = (idx == IDX_LAST) ? S_FIN : S_FETCH;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && line_start) line_y_p0 <= line_y;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      hit_cnt      <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      line_done    <= 1'b0;
      line_overrun <= 1'b0;
      drw_col_base <= '0;
      drw_flip     <= 1'b0;
      drw_frame_id <= '0;
      drw_row_off  <= '0;
    end else begin
      state        <= state_next;
      line_done    <= (state == S_FIN);
      // A start that arrives during FIN still counts as an overrun; the line is not retried.
      line_overrun <= line_start && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (line_start) begin
            idx      <= IDX_FIRST;
            hit_cnt  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_CHECK: begin
          if (hit_p1 && cap_p1) begin
            overflow <= 1'b1;
          end else if (hit_p1) begin
            drw_col_base <= attr_q[9:0];
            drw_flip     <= attr_q[30];
            drw_frame_id <= attr_q[29:22];
            drw_row_off  <= delta_p1[3:0];
          end
        end
        S_LAUNCH: hit_cnt <= hit_cnt + CW'(1);
        S_NEXT:   if (idx != IDX_LAST) idx <= idx + IDX_STEP;
        S_FIN:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
